// File: rtl/seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : seg_scan_decoder
// Purpose  : Receive-side monitor for a multiplexed, active-low seven-segment
//            display bus. Rebuilds the four BCD digits being scanned out,
//            debounces scan transitions, checks every glyph and flags a
//            stalled scan.
// Ports    : clk           - rising-edge clock
//            reset         - synchronous, active-low
//            an[3:0]       - anode enables, active-low (an[3] = MS digit)
//            digit[7:0]    - segments, active-low {dp,g,f,e,d,c,b,a}
//            bcd_out[15:0] - last complete frame {d3,d2,d1,d0}
//            frame_valid   - 1-cycle pulse when bcd_out updates
//            frame_changed - 1-cycle pulse with frame_valid when value differs
//            glyph_err     - frame held an invalid glyph (held to next frame)
//            stalled       - timeout counter saturated
// Revision : 1.0 - initial release
// ============================================================================
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  an,
    input  logic [7:0]  digit,
    output logic [15:0] bcd_out,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        glyph_err,
    output logic        stalled
);

    localparam int c_CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int c_TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_SETTLE  = c_CNT_W'(SETTLE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);
    localparam logic [c_TMO_W-1:0] c_TMO_MAX = c_TMO_W'(TIMEOUT_CYCLES);
    localparam logic [c_TMO_W-1:0] c_TMO_ONE = c_TMO_W'(1);

    typedef enum logic [1:0] {
        ST_WAIT   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HELD   = 2'd2
    } state_t;

    // Input register plus one-cycle history for change detection.
    // The decimal point never takes part in decoding or debouncing.
    logic [3:0]         r_an;
    logic [6:0]         r_seg;
    logic [3:0]         r_an_prev;
    logic [6:0]         r_seg_prev;
    logic               w_unused_dp;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_capture;

    logic               w_legal;
    logic [1:0]         w_sel;
    logic               w_changed;
    logic [3:0]         w_glyph;

    logic [15:0]        r_slots;
    logic [3:0]         r_mask;
    logic               r_pend;
    logic [3:0]         w_mask_nxt;
    logic               w_pend_nxt;
    logic               w_any_bad;

    logic [15:0]        r_bcd;
    logic               r_fv;
    logic               r_fc;
    logic               r_ge;
    logic [c_TMO_W-1:0] r_tmo;

    assign w_unused_dp = digit[7];
    assign w_changed   = (r_an != r_an_prev) || (r_seg != r_seg_prev);

    // A legal select has exactly one anode low; it also names the slot.
    always_comb begin
        w_legal = 1'b1;
        w_sel   = 2'd0;
        case (r_an)
            4'b1110: w_sel = 2'd0;
            4'b1101: w_sel = 2'd1;
            4'b1011: w_sel = 2'd2;
            4'b0111: w_sel = 2'd3;
            default: w_legal = 1'b0;
        endcase
    end

    always_comb begin
        case (r_seg)
            7'h40:   w_glyph = 4'd0;
            7'h79:   w_glyph = 4'd1;
            7'h24:   w_glyph = 4'd2;
            7'h30:   w_glyph = 4'd3;
            7'h19:   w_glyph = 4'd4;
            7'h12:   w_glyph = 4'd5;
            7'h02:   w_glyph = 4'd6;
            7'h78:   w_glyph = 4'd7;
            7'h00:   w_glyph = 4'd8;
            7'h10:   w_glyph = 4'd9;
            default: w_glyph = 4'hF;
        endcase
    end

    // Debounce FSM. The counter holds the length of the current run of
    // identical legal samples; a capture fires the cycle it reaches
    // SETTLE_CYCLES, and HELD prevents re-capturing the same run.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        case (r_state)
            ST_WAIT: begin
                if (w_legal) begin
                    w_cnt_nxt   = c_CNT_ONE;
                    w_state_nxt = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (!w_legal) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_WAIT;
                end else if (w_changed) begin
                    w_cnt_nxt = c_CNT_ONE;
                end else begin
                    w_cnt_nxt = r_cnt + c_CNT_ONE;
                end
            end
            ST_HELD: begin
                if (w_changed) begin
                    if (w_legal) begin
                        w_cnt_nxt   = c_CNT_ONE;
                        w_state_nxt = ST_SETTLE;
                    end else begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = ST_WAIT;
            end
        endcase
        if ((w_state_nxt == ST_SETTLE) && (w_cnt_nxt == c_SETTLE)) begin
            w_capture   = 1'b1;
            w_state_nxt = ST_HELD;
        end
    end

    // Frame completion clears the mask first; a capture in the same cycle
    // then sets its own bit on top of the cleared mask.
    always_comb begin
        w_mask_nxt = r_pend ? 4'b0000 : r_mask;
        if (w_capture) begin
            w_mask_nxt[w_sel] = 1'b1;
        end
        w_pend_nxt = w_capture && (w_mask_nxt == 4'b1111);
    end

    assign w_any_bad = (r_slots[3:0]   == 4'hF) || (r_slots[7:4]   == 4'hF) ||
                       (r_slots[11:8]  == 4'hF) || (r_slots[15:12] == 4'hF);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_an       <= 4'hF;
            r_seg      <= 7'h7F;
            r_an_prev  <= 4'hF;
            r_seg_prev <= 7'h7F;
            r_state    <= ST_WAIT;
            r_cnt      <= '0;
            r_slots    <= '0;
            r_mask     <= 4'b0000;
            r_pend     <= 1'b0;
            r_bcd      <= '0;
            r_fv       <= 1'b0;
            r_fc       <= 1'b0;
            r_ge       <= 1'b0;
            r_tmo      <= '0;
        end else begin
            r_an       <= an;
            r_seg      <= digit[6:0];
            r_an_prev  <= r_an;
            r_seg_prev <= r_seg;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_mask     <= w_mask_nxt;
            r_pend     <= w_pend_nxt;
            if (w_capture) begin
                r_slots[{w_sel, 2'b00} +: 4] <= w_glyph;
            end
            r_fv <= r_pend;
            r_fc <= r_pend && (r_slots != r_bcd);
            if (r_pend) begin
                r_bcd <= r_slots;
                r_ge  <= w_any_bad;
            end
            if (w_capture) begin
                r_tmo <= '0;
            end else if (r_tmo != c_TMO_MAX) begin
                r_tmo <= r_tmo + c_TMO_ONE;
            end
        end
    end

    assign bcd_out       = r_bcd;
    assign frame_valid   = r_fv;
    assign frame_changed = r_fc;
    assign glyph_err     = r_ge;
    assign stalled       = (r_tmo == c_TMO_MAX);

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg_scan_decoder
// Purpose  : Self-checking bench for seg_scan_decoder. Directed scenarios are
//            checked against constants; a random scan is checked cycle by
//            cycle against a run-length reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg_scan_decoder;

    localparam int S = 4;
    localparam int T = 16;

    logic        clk;
    logic        reset;
    logic [3:0]  an;
    logic [7:0]  digit;
    logic [15:0] bcd_out;
    logic        frame_valid;
    logic        frame_changed;
    logic        glyph_err;
    logic        stalled;

    int checks;
    int errors;

    seg_scan_decoder #(
        .SETTLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .an            (an),
        .digit         (digit),
        .bcd_out       (bcd_out),
        .frame_valid   (frame_valid),
        .frame_changed (frame_changed),
        .glyph_err     (glyph_err),
        .stalled       (stalled)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [6:0] glyph_pat [10];

    // Reference model: registered sample, its run length, slots and outputs.
    logic [3:0]  q_an;
    logic [6:0]  q_seg;
    int          m_run;
    logic [3:0]  m_slot [4];
    logic [3:0]  m_mask;
    bit          m_pend;
    logic [15:0] m_bcd;
    bit          m_fv;
    bit          m_fc;
    bit          m_ge;
    int          m_tmo;

    // Observations of frame events during directed phases.
    int          ph_tick;
    int          fv_cnt;
    int          fv_tick;
    logic [15:0] fv_bcd;
    logic        fv_fc;
    logic        fv_ge;

    function automatic logic [7:0] seg_of(input int n);
        return {1'b1, glyph_pat[n]};
    endfunction

    function automatic logic [3:0] ref_glyph(input logic [6:0] p);
        for (int k = 0; k < 10; k++) begin
            if (glyph_pat[k] == p) return 4'(k);
        end
        return 4'hF;
    endfunction

    // Slot index of a legal select, -1 for a blank phase.
    function automatic int ref_slot(input logic [3:0] a);
        if ($countones(a) != 3) return -1;
        for (int k = 0; k < 4; k++) begin
            if (a[k] == 1'b0) return k;
        end
        return -1;
    endfunction

    task automatic tick(input logic [3:0] a, input logic [7:0] d, input logic rn);
        int          idx;
        bit          cap;
        logic [15:0] nb;
        an    = a;
        digit = d;
        reset = rn;
        @(posedge clk);
        if (!rn) begin
            q_an   = 4'hF;
            q_seg  = 7'h7F;
            m_run  = 0;
            for (int k = 0; k < 4; k++) m_slot[k] = 4'h0;
            m_mask = 4'h0;
            m_pend = 1'b0;
            m_bcd  = 16'h0;
            m_fv   = 1'b0;
            m_fc   = 1'b0;
            m_ge   = 1'b0;
            m_tmo  = 0;
        end else begin
            idx  = ref_slot(q_an);
            cap  = (idx >= 0) && (m_run == S);
            m_fv = m_pend;
            m_fc = 1'b0;
            if (m_pend) begin
                nb     = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
                m_fc   = (nb != m_bcd);
                m_bcd  = nb;
                m_ge   = (m_slot[0] == 4'hF) || (m_slot[1] == 4'hF) ||
                         (m_slot[2] == 4'hF) || (m_slot[3] == 4'hF);
                m_mask = 4'h0;
            end
            m_pend = 1'b0;
            if (cap) begin
                m_slot[idx] = ref_glyph(q_seg);
                m_mask[idx] = 1'b1;
                m_pend      = (m_mask == 4'hF);
                m_tmo       = 0;
            end else if (m_tmo < T) begin
                m_tmo++;
            end
            if ((a == q_an) && (d[6:0] == q_seg)) m_run++;
            else m_run = 1;
            q_an  = a;
            q_seg = d[6:0];
        end
        #1;
        if (frame_valid === 1'b1) begin
            fv_cnt++;
            fv_tick = ph_tick;
            fv_bcd  = bcd_out;
            fv_fc   = frame_changed;
            fv_ge   = glyph_err;
        end
    endtask

    task automatic phase(input logic [3:0] a, input logic [7:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            ph_tick = i;
            tick(a, d, 1'b1);
        end
    endtask

    task automatic scan4(input int g0, input int g1, input int g2, input int g3, input int n);
        phase(4'hE, seg_of(g0), n);
        phase(4'hD, seg_of(g1), n);
        phase(4'hB, seg_of(g2), n);
        phase(4'h7, seg_of(g3), n);
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) tick(4'hE, seg_of(5), 1'b0);
        checks++; if (bcd_out !== 16'h0) begin errors++; $display("FAIL reset_bcd: got %h expected 0000", bcd_out); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_fv: got %b expected 0", frame_valid); end
        checks++; if (frame_changed !== 1'b0) begin errors++; $display("FAIL reset_fc: got %b expected 0", frame_changed); end
        checks++; if (glyph_err !== 1'b0) begin errors++; $display("FAIL reset_ge: got %b expected 0", glyph_err); end
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL reset_stalled: got %b expected 0", stalled); end
    endtask

    task automatic test_scan_basic();
        fv_cnt = 0;
        scan4(9, 4, 1, 0, 8);
        checks++; if (fv_cnt !== 1) begin errors++; $display("FAIL basic_fv_count: got %0d expected 1", fv_cnt); end
        checks++; if (fv_bcd !== 16'h0149) begin errors++; $display("FAIL basic_bcd: got %h expected 0149", fv_bcd); end
        checks++; if (fv_ge !== 1'b0) begin errors++; $display("FAIL basic_ge: got %b expected 0", fv_ge); end
        checks++; if (fv_fc !== 1'b1) begin errors++; $display("FAIL basic_fc: got %b expected 1", fv_fc); end
        checks++; if (fv_tick !== S + 1) begin errors++; $display("FAIL basic_latency: got %0d expected %0d", fv_tick, S + 1); end
        checks++; if (bcd_out !== 16'h0149) begin errors++; $display("FAIL basic_hold: got %h expected 0149", bcd_out); end
    endtask

    task automatic test_repeat();
        fv_cnt = 0;
        scan4(9, 4, 1, 0, 8);
        checks++; if (fv_cnt !== 1) begin errors++; $display("FAIL repeat_fv_count: got %0d expected 1", fv_cnt); end
        checks++; if (fv_fc !== 1'b0) begin errors++; $display("FAIL repeat_fc: got %b expected 0", fv_fc); end
        checks++; if (fv_bcd !== 16'h0149) begin errors++; $display("FAIL repeat_bcd: got %h expected 0149", fv_bcd); end
        fv_cnt = 0;
        scan4(2, 4, 1, 0, 8);
        checks++; if (fv_bcd !== 16'h0142) begin errors++; $display("FAIL change_bcd: got %h expected 0142", fv_bcd); end
        checks++; if (fv_fc !== 1'b1) begin errors++; $display("FAIL change_fc: got %b expected 1", fv_fc); end
    endtask

    task automatic test_short_and_glitch();
        fv_cnt = 0;
        scan4(3, 5, 6, 7, S - 1);
        scan4(8, 9, 2, 1, S - 1);
        checks++; if (fv_cnt !== 0) begin errors++; $display("FAIL short_no_frame: got %0d expected 0", fv_cnt); end
        fv_cnt = 0;
        phase(4'hE, seg_of(9), 8);
        phase(4'hD, seg_of(4), 8);
        phase(4'hB, seg_of(1), 8);
        for (int i = 0; i < 12; i++) begin
            ph_tick = i;
            tick(4'h7, (i == 2) ? seg_of(8) : seg_of(0), 1'b1);
        end
        // Run restarts at tick 3, reaches S samples at tick 3+S-1, frame one edge after capture.
        checks++; if (fv_cnt !== 1) begin errors++; $display("FAIL glitch_fv_count: got %0d expected 1", fv_cnt); end
        checks++; if (fv_tick !== 3 + S + 1) begin errors++; $display("FAIL glitch_latency: got %0d expected %0d", fv_tick, 3 + S + 1); end
        checks++; if (fv_bcd !== 16'h0149) begin errors++; $display("FAIL glitch_bcd: got %h expected 0149", fv_bcd); end
    endtask

    task automatic test_blank_invalid();
        fv_cnt = 0;
        phase(4'hE, seg_of(3), 8);
        phase(4'b1100, seg_of(8), 2);
        phase(4'hD, seg_of(5), 8);
        phase(4'hF, 8'hFF, 2);
        phase(4'hB, 8'hFF, 8);
        phase(4'b0000, seg_of(8), 2);
        phase(4'h7, seg_of(7), 8);
        checks++; if (fv_cnt !== 1) begin errors++; $display("FAIL invalid_fv_count: got %0d expected 1", fv_cnt); end
        checks++; if (fv_bcd !== 16'h7F53) begin errors++; $display("FAIL invalid_bcd: got %h expected 7f53", fv_bcd); end
        checks++; if (fv_ge !== 1'b1) begin errors++; $display("FAIL invalid_ge: got %b expected 1", fv_ge); end
        phase(4'hE, seg_of(9), 8);
        checks++; if (glyph_err !== 1'b1) begin errors++; $display("FAIL ge_held: got %b expected 1", glyph_err); end
        fv_cnt = 0;
        phase(4'hD, seg_of(4), 8);
        phase(4'hB, seg_of(1), 8);
        phase(4'h7, seg_of(0), 8);
        checks++; if (fv_bcd !== 16'h0149) begin errors++; $display("FAIL clean_bcd: got %h expected 0149", fv_bcd); end
        checks++; if (fv_ge !== 1'b0) begin errors++; $display("FAIL clean_ge: got %b expected 0", fv_ge); end
    endtask

    task automatic test_timeout();
        fv_cnt = 0;
        phase(4'hE, seg_of(1), 8);
        phase(4'hD, seg_of(2), 8);
        // Counter is 3 after the D phase; idle tick i leaves it at i+4.
        for (int i = 0; i < 20; i++) begin
            tick(4'hF, 8'hFF, 1'b1);
            if (i == 11) begin
                checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL stall_early: got %b expected 0", stalled); end
            end
            if (i == 12) begin
                checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL stall_set: got %b expected 1", stalled); end
            end
        end
        for (int i = 0; i < 8; i++) begin
            tick(4'hB, seg_of(3), 1'b1);
            if (i == S - 1) begin
                checks++; if (stalled !== 1'b1) begin errors++; $display("FAIL stall_hold: got %b expected 1", stalled); end
            end
            if (i == S) begin
                checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL stall_clear: got %b expected 0", stalled); end
            end
        end
        phase(4'h7, seg_of(4), 8);
        checks++; if (fv_cnt !== 1) begin errors++; $display("FAIL stall_fv_count: got %0d expected 1", fv_cnt); end
        checks++; if (fv_bcd !== 16'h4321) begin errors++; $display("FAIL stall_partial_bcd: got %h expected 4321", fv_bcd); end
    endtask

    task automatic test_reset_partial();
        phase(4'hE, seg_of(5), 8);
        phase(4'hD, seg_of(6), 8);
        tick(4'hB, seg_of(7), 1'b0);
        tick(4'hB, seg_of(7), 1'b0);
        checks++; if (bcd_out !== 16'h0) begin errors++; $display("FAIL rstp_bcd: got %h expected 0000", bcd_out); end
        checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL rstp_fv: got %b expected 0", frame_valid); end
        checks++; if (stalled !== 1'b0) begin errors++; $display("FAIL rstp_stalled: got %b expected 0", stalled); end
        fv_cnt = 0;
        phase(4'hB, seg_of(7), 8);
        phase(4'h7, seg_of(8), 8);
        phase(4'hE, seg_of(1), 8);
        checks++; if (fv_cnt !== 0) begin errors++; $display("FAIL rstp_early_frame: got %0d expected 0", fv_cnt); end
        phase(4'hD, seg_of(2), 8);
        checks++; if (fv_cnt !== 1) begin errors++; $display("FAIL rstp_fv_count: got %0d expected 1", fv_cnt); end
        checks++; if (fv_bcd !== 16'h8721) begin errors++; $display("FAIL rstp_bcd_frame: got %h expected 8721", fv_bcd); end
    endtask

    task automatic test_random();
        logic [3:0] a;
        logic [7:0] d;
        int         n;
        logic       rn;
        for (int p = 0; p < 120; p++) begin
            if ($urandom_range(0, 4) != 0) a = 4'hF ^ (4'h1 << $urandom_range(0, 3));
            else a = 4'($urandom());
            if ($urandom_range(0, 6) != 0) d = seg_of($urandom_range(0, 9));
            else d = 8'($urandom());
            d[7] = 1'($urandom());
            n  = $urandom_range(1, 9);
            if (ref_slot(a) < 0 && $urandom_range(0, 3) == 0) n = 18;
            rn = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
            for (int i = 0; i < n; i++) begin
                tick(a, d, (i < 2) ? rn : 1'b1);
                checks++; if (bcd_out !== m_bcd) begin errors++; $display("FAIL rnd_bcd p%0d: got %h expected %h", p, bcd_out, m_bcd); end
                checks++; if (frame_valid !== m_fv) begin errors++; $display("FAIL rnd_fv p%0d: got %b expected %b", p, frame_valid, m_fv); end
                checks++; if (frame_changed !== m_fc) begin errors++; $display("FAIL rnd_fc p%0d: got %b expected %b", p, frame_changed, m_fc); end
                checks++; if (glyph_err !== m_ge) begin errors++; $display("FAIL rnd_ge p%0d: got %b expected %b", p, glyph_err, m_ge); end
                checks++; if (stalled !== (m_tmo == T)) begin errors++; $display("FAIL rnd_stalled p%0d: got %b expected %b", p, stalled, (m_tmo == T)); end
            end
        end
    endtask

    initial begin
        glyph_pat[0] = 7'h40; glyph_pat[1] = 7'h79; glyph_pat[2] = 7'h24;
        glyph_pat[3] = 7'h30; glyph_pat[4] = 7'h19; glyph_pat[5] = 7'h12;
        glyph_pat[6] = 7'h02; glyph_pat[7] = 7'h78; glyph_pat[8] = 7'h00;
        glyph_pat[9] = 7'h10;
        checks  = 0;
        errors  = 0;
        fv_cnt  = 0;
        fv_tick = -1;
        fv_bcd  = 16'h0;
        fv_fc   = 1'b0;
        fv_ge   = 1'b0;
        ph_tick = 0;
        q_an    = 4'hF;
        q_seg   = 7'h7F;
        m_run   = 0;
        for (int k = 0; k < 4; k++) m_slot[k] = 4'h0;
        m_mask  = 4'h0;
        m_pend  = 1'b0;
        m_bcd   = 16'h0;
        m_fv    = 1'b0;
        m_fc    = 1'b0;
        m_ge    = 1'b0;
        m_tmo   = 0;
        reset   = 1'b0;
        an      = 4'hF;
        digit   = 8'hFF;

        test_reset();
        test_scan_basic();
        test_repeat();
        test_short_and_glitch();
        test_blank_invalid();
        test_timeout();
        test_reset_partial();
        test_random();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
